// File: rtl/fp_div_pkg.sv
// Shared types and constants for the FP divide mantissa datapath.
package fp_div_pkg;

    localparam int unsigned MANT_W = 24;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/div_trial_subtract.sv
// Combinational trial subtraction r - d, built as r + ~d + 1 on a ripple-carry chain.
module div_trial_subtract #(
    parameter int unsigned W = 25
) (
    input  logic [W-1:0] r_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] diff_o,
    output logic         nonneg_o
);

    logic [W:0]   carry;
    logic [W-1:0] d_inv;

    assign d_inv = ~d_i;

    // Carry out of the top bit is the inverted borrow: set when r >= d.
    always_comb begin
        carry    = '0;
        diff_o   = '0;
        carry[0] = 1'b1;
        for (int i = 0; i < int'(W); i++) begin
            diff_o[i]    = r_i[i] ^ d_inv[i] ^ carry[i];
            carry[i + 1] = (r_i[i] & d_inv[i]) | (carry[i] & (r_i[i] ^ d_inv[i]));
        end
    end

    assign nonneg_o = carry[W];

endmodule

// File: rtl/seq_restoring_divider.sv
// Unsigned restoring divider, one quotient bit per clock, valid/ready on both sides.
module seq_restoring_divider
    import fp_div_pkg::*;
#(
    parameter int unsigned N = MANT_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         div_by_zero
);

    localparam int unsigned CW = $clog2(N + 1);
    localparam int unsigned RW = N + 1;

    div_state_e    state_q;
    logic [N-1:0]  q_q;
    logic [N-1:0]  d_q;
    logic [RW-1:0] r_q;
    logic [CW-1:0] cnt_q;
    logic          in_ready_q;
    logic          out_valid_q;
    logic          dz_q;

    logic [RW-1:0] r_shift;
    logic [RW-1:0] trial_diff;
    logic          trial_nonneg;

    // Shift {R,Q} left by one; the dividend MSB walks into the remainder.
    assign r_shift = {r_q[N-1:0], q_q[N-1]};

    div_trial_subtract #(
        .W(RW)
    ) u_trial (
        .r_i     (r_shift),
        .d_i     ({1'b0, d_q}),
        .diff_o  (trial_diff),
        .nonneg_o(trial_nonneg)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            q_q         <= '0;
            d_q         <= '0;
            r_q         <= '0;
            cnt_q       <= '0;
            dz_q        <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid && in_ready_q) begin
                        q_q        <= dividend;
                        d_q        <= divisor;
                        r_q        <= '0;
                        cnt_q      <= CW'(N);
                        in_ready_q <= 1'b0;
                        // Zero divisor bypasses iteration with the saturated quotient.
                        if (divisor == '0) begin
                            dz_q        <= 1'b1;
                            q_q         <= '1;
                            r_q         <= RW'(dividend);
                            out_valid_q <= 1'b1;
                            state_q     <= DONE;
                        end else begin
                            dz_q    <= 1'b0;
                            state_q <= CALC;
                        end
                    end
                end
                CALC: begin
                    r_q   <= trial_nonneg ? trial_diff : r_shift;
                    q_q   <= {q_q[N-2:0], trial_nonneg};
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (out_valid_q && out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign quotient    = q_q;
    assign remainder   = r_q[N-1:0];
    assign div_by_zero = dz_q;

    // Final remainder is below the divisor, so the guard bit is clear.
    a_rem_msb_clear: assert property (@(posedge clk) disable iff (reset)
        (state_q == DONE) |-> !r_q[N]);

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Directed and randomized checks of seq_restoring_divider at N=8 and N=24.
module tb_seq_restoring_divider;

    logic clk;
    logic rst;

    logic       iv8, ir8, ov8, or8, dz8;
    logic [7:0] a8, b8, q8, r8;

    logic        iv24, ir24, ov24, or24, dz24;
    logic [23:0] a24, b24, q24, r24;

    int n_cmp;
    int n_err;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] q;
        logic [7:0] r;
        logic       dz;
        int         lat;
    } vec8_t;

    vec8_t vecs[7];

    seq_restoring_divider #(.N(8)) u_dut8 (
        .clk        (clk),
        .reset      (rst),
        .in_valid   (iv8),
        .in_ready   (ir8),
        .dividend   (a8),
        .divisor    (b8),
        .out_valid  (ov8),
        .out_ready  (or8),
        .quotient   (q8),
        .remainder  (r8),
        .div_by_zero(dz8)
    );

    seq_restoring_divider #(.N(24)) u_dut24 (
        .clk        (clk),
        .reset      (rst),
        .in_valid   (iv24),
        .in_ready   (ir24),
        .dividend   (a24),
        .divisor    (b24),
        .out_valid  (ov24),
        .out_ready  (or24),
        .quotient   (q24),
        .remainder  (r24),
        .div_by_zero(dz24)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Present operands, wait for accept, then count cycles (accept edge = 1) until out_valid.
    task automatic start8(input logic [7:0] a, input logic [7:0] b, output int lat, output int lo);
        int g;
        @(negedge clk);
        iv8 = 1'b1;
        a8  = a;
        b8  = b;
        g   = 0;
        while (!ir8 && g < 50) begin
            @(negedge clk);
            g++;
        end
        @(posedge clk);
        @(negedge clk);
        iv8 = 1'b0;
        a8  = 8'($urandom);
        b8  = 8'($urandom);
        lat = 1;
        lo  = 0;
        while (!ov8 && lat < 100) begin
            if (!ir8) lo++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic drain8(input string tag);
        or8 = 1'b1;
        @(negedge clk);
        or8 = 1'b0;
        check({tag, "/ir_after"}, 64'(ir8), 64'(1));
        check({tag, "/ov_after"}, 64'(ov8), 64'(0));
    endtask

    task automatic run24(input logic [23:0] a, input logic [23:0] b,
                         input logic [23:0] eq, input logic [23:0] er, input string tag);
        int lat;
        @(negedge clk);
        iv24 = 1'b1;
        a24  = a;
        b24  = b;
        lat  = 0;
        while (!ir24 && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        @(posedge clk);
        @(negedge clk);
        iv24 = 1'b0;
        lat  = 1;
        while (!ov24 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "/q"}, 64'(q24), 64'(eq));
        check({tag, "/r"}, 64'(r24), 64'(er));
        check({tag, "/lat"}, 64'(lat), 64'(25));
        or24 = 1'b1;
        @(negedge clk);
        or24 = 1'b0;
    endtask

    initial begin
        int lat;
        int lo;
        logic [23:0] ra;
        logic [23:0] rb;

        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        iv8 = 1'b0; a8 = '0; b8 = '0; or8 = 1'b0;
        iv24 = 1'b0; a24 = '0; b24 = '0; or24 = 1'b0;

        vecs[0] = '{8'd255, 8'd1,   8'd255, 8'd0,  1'b0, 9};
        vecs[1] = '{8'd5,   8'd9,   8'd0,   8'd5,  1'b0, 9};
        vecs[2] = '{8'd200, 8'd200, 8'd1,   8'd0,  1'b0, 9};
        vecs[3] = '{8'd0,   8'd3,   8'd0,   8'd0,  1'b0, 9};
        vecs[4] = '{8'd42,  8'd0,   8'd255, 8'd42, 1'b1, 1};
        vecs[5] = '{8'd42,  8'd6,   8'd7,   8'd0,  1'b0, 9};
        vecs[6] = '{8'd255, 8'd255, 8'd1,   8'd0,  1'b0, 9};

        repeat (3) @(negedge clk);
        check("rst/ir", 64'(ir8), 64'(1));
        check("rst/ov", 64'(ov8), 64'(0));
        check("rst/q",  64'(q8),  64'(0));
        check("rst/r",  64'(r8),  64'(0));
        check("rst/dz", 64'(dz8), 64'(0));
        rst = 1'b0;

        // Basic 100/7
        start8(8'd100, 8'd7, lat, lo);
        check("t1/lat", 64'(lat), 64'(9));
        check("t1/ir_low_calc", 64'(lo), 64'(8));
        check("t1/ir_done", 64'(ir8), 64'(0));
        check("t1/q",  64'(q8),  64'(14));
        check("t1/r",  64'(r8),  64'(2));
        check("t1/dz", 64'(dz8), 64'(0));
        drain8("t1");

        // Boundary and divide-by-zero vectors, back to back
        for (int i = 0; i < 7; i++) begin
            start8(vecs[i].a, vecs[i].b, lat, lo);
            check($sformatf("v%0d/lat", i), 64'(lat), 64'(vecs[i].lat));
            check($sformatf("v%0d/q", i),  64'(q8),  64'(vecs[i].q));
            check($sformatf("v%0d/r", i),  64'(r8),  64'(vecs[i].r));
            check($sformatf("v%0d/dz", i), 64'(dz8), 64'(vecs[i].dz));
            drain8($sformatf("v%0d", i));
        end

        // Backpressure: result holds, new operands ignored
        start8(8'd100, 8'd7, lat, lo);
        for (int k = 0; k < 5; k++) begin
            iv8 = k[0];
            a8  = 8'd1;
            b8  = 8'd1;
            check($sformatf("bp%0d/q", k),  64'(q8),  64'(14));
            check($sformatf("bp%0d/r", k),  64'(r8),  64'(2));
            check($sformatf("bp%0d/ir", k), 64'(ir8), 64'(0));
            check($sformatf("bp%0d/ov", k), 64'(ov8), 64'(1));
            @(negedge clk);
        end
        iv8 = 1'b0;
        drain8("bp");

        // Reset three cycles into CALC
        @(negedge clk);
        iv8 = 1'b1; a8 = 8'd100; b8 = 8'd7;
        @(posedge clk);
        @(negedge clk);
        iv8 = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("mrst/ir", 64'(ir8), 64'(1));
        check("mrst/ov", 64'(ov8), 64'(0));
        check("mrst/q",  64'(q8),  64'(0));
        check("mrst/r",  64'(r8),  64'(0));
        rst = 1'b0;
        start8(8'd9, 8'd2, lat, lo);
        check("mrst9/q", 64'(q8), 64'(4));
        check("mrst9/r", 64'(r8), 64'(1));
        drain8("mrst9");

        // Reset coincident with an operand handshake captures nothing
        @(negedge clk);
        rst = 1'b1; iv8 = 1'b1; a8 = 8'd9; b8 = 8'd2;
        @(negedge clk);
        rst = 1'b0; iv8 = 1'b0;
        repeat (12) @(negedge clk);
        check("rsths/ir", 64'(ir8), 64'(1));
        check("rsths/ov", 64'(ov8), 64'(0));

        // N=24 directed corners
        run24(24'hFFFFFF, 24'hFFFFFF, 24'd1, 24'd0, "w24_ones");
        run24(24'hABCDEF, 24'd1, 24'hABCDEF, 24'd0, "w24_div1");
        run24(24'd12345, 24'd1000, 24'd12, 24'd345, "w24_dec");

        // N=24 random against the bench's arithmetic
        for (int i = 0; i < 1000; i++) begin
            ra = 24'($urandom);
            rb = 24'($urandom) >> $urandom_range(0, 23);
            if (rb == '0) rb = 24'd1;
            run24(ra, rb, ra / rb, ra % rb, $sformatf("rnd%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
